// File: rtl/l2_instr_responder_pkg.sv
// Shared types and field positions for the L2 instruction responder stub.
// Used by the top with and without L2_STATS_EN.
package l2_instr_responder_pkg;

    // Byte offset within a word, then the word index, then the tag
    localparam int BLK_OFFSET_W = 2;
    localparam int INDEX_LSB    = BLK_OFFSET_W;

    // Latency counter covers RESP_LATENCY up to 15
    localparam int CNT_W  = 4;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        L2R_IDLE    = 2'b00,
        L2R_WAIT    = 2'b01,
        L2R_RESPOND = 2'b10,
        L2R_RELEASE = 2'b11
    } l2r_state_e;

    function automatic logic [STAT_W-1:0] sat_inc(
        input logic [STAT_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/l2_instr_responder_if.sv
// Common instruction bus as seen by the L2 responder.
// Data and strobe are shared tristate nets; grant is the OR of all grants.
interface l2_instr_responder_if #(
    parameter int ADDR_W = 32
);
    wire              Bus_Gnt_any;
    wire [ADDR_W-1:0] Address_Com;
    wire [ADDR_W-1:0] Data_Bus_Com;
    wire              Data_in_Bus;

    // Weak terminator so the strobe reads low while nobody drives it
    pulldown (Data_in_Bus);

    modport master (
        output Bus_Gnt_any,
        inout  Address_Com,
        inout  Data_Bus_Com,
        inout  Data_in_Bus
    );

    modport slave (
        input  Bus_Gnt_any,
        inout  Address_Com,
        inout  Data_Bus_Com,
        inout  Data_in_Bus
    );
endinterface

// File: rtl/l2_stub_mem.sv
// Word-wide stub memory: synchronous backdoor write, asynchronous read.
// Contents are never cleared by reset.
module l2_stub_mem #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 10
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);
    logic [DATA_W-1:0] r_mem [2**IDX_W];

    // Backdoor load port
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/l2_instr_responder.sv
// Stub L2 that answers instruction line fills on the common bus.
// Optional L2_STATS_EN adds saturating Fill_count / Abort_count outputs.
module l2_instr_responder
    import l2_instr_responder_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int MEM_WORDS_LOG2 = 10,
    parameter int RESP_LATENCY   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    l2_instr_responder_if.slave       bus,
    input  logic                      Mem_wr_en,
    input  logic [MEM_WORDS_LOG2-1:0] Mem_wr_addr,
    input  logic [ADDR_W-1:0]         Mem_wr_data,
`ifdef L2_STATS_EN
    output logic [STAT_W-1:0]         Fill_count,
    output logic [STAT_W-1:0]         Abort_count,
`endif
    output logic                      Busy
);
    localparam int WORD_W = ADDR_W - INDEX_LSB;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RESP_LATENCY - 1);
    localparam bit LAT_ONE = (RESP_LATENCY == 1);

    l2r_state_e          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [WORD_W-1:0]   r_word;
    logic                r_busy;
    logic                r_resp;

    logic                w_gnt;
    logic [WORD_W-1:0]   w_req_word;
    logic                w_new_req;
    logic                w_capture;
    logic                w_abort;
    logic [ADDR_W-1:0]   w_rd_data;
    logic                w_unused_ofs;

    assign w_gnt        = bus.Bus_Gnt_any;
    assign w_req_word   = bus.Address_Com[ADDR_W-1:INDEX_LSB];
    assign w_unused_ofs = &{1'b0, bus.Address_Com[INDEX_LSB-1:0]};
    assign w_new_req    = (w_req_word != r_word);

    // A capture happens from IDLE, or from RESPOND for a new requester
    assign w_capture = w_gnt &&
        ((r_state == L2R_IDLE) ||
         ((r_state == L2R_RESPOND) && w_new_req));
    assign w_abort   = !w_gnt && (r_state == L2R_WAIT);

    l2_stub_mem #(
        .DATA_W (ADDR_W),
        .IDX_W  (MEM_WORDS_LOG2)
    ) u_mem (
        .i_clk     (clk),
        .i_wr_en   (Mem_wr_en),
        .i_wr_addr (Mem_wr_addr),
        .i_wr_data (Mem_wr_data),
        .i_rd_addr (r_word[MEM_WORDS_LOG2-1:0]),
        .o_rd_data (w_rd_data)
    );

    // Request FSM with registered Busy and bus-enable outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= L2R_IDLE;
            r_cnt   <= '0;
            r_word  <= '0;
            r_busy  <= 1'b0;
            r_resp  <= 1'b0;
        end else if (w_capture) begin
            r_word  <= w_req_word;
            r_cnt   <= LAT_LOAD;
            r_state <= LAT_ONE ? L2R_RESPOND : L2R_WAIT;
            r_resp  <= LAT_ONE;
            r_busy  <= 1'b1;
        end else begin
            unique case (r_state)
                L2R_IDLE: begin
                    r_busy <= 1'b0;
                end
                L2R_WAIT: begin
                    if (w_abort) begin
                        r_state <= L2R_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_W'(1)) begin
                        r_cnt   <= '0;
                        r_state <= L2R_RESPOND;
                        r_resp  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                L2R_RESPOND: begin
                    if (!w_gnt) begin
                        r_state <= L2R_RELEASE;
                        r_resp  <= 1'b0;
                    end
                end
                L2R_RELEASE: begin
                    r_state <= L2R_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Reset clears r_resp, so the bus floats immediately
    assign bus.Data_Bus_Com = r_resp ? w_rd_data : {ADDR_W{1'bz}};
    assign bus.Data_in_Bus  = r_resp ? 1'b1 : 1'bz;
    assign Busy             = r_busy;

`ifdef L2_STATS_EN
    logic [STAT_W-1:0] r_fill;
    logic [STAT_W-1:0] r_abort;

    // Saturating counts of fills started and waits abandoned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill  <= '0;
            r_abort <= '0;
        end else begin
            if (w_capture) r_fill <= sat_inc(r_fill);
            if (w_abort) r_abort <= sat_inc(r_abort);
        end
    end

    assign Fill_count  = r_fill;
    assign Abort_count = r_abort;
`endif
endmodule

// File: tb/tb_l2_instr_responder.sv
// Bench for l2_instr_responder: directed table, corner sequences, random.
// Two instances: RESP_LATENCY 2 (index 0) and RESP_LATENCY 3 (index 1).
module tb_l2_instr_responder;
    localparam int AW = 32;
    localparam int ML = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          gnt2 = 1'b0;
    logic          gnt3 = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          wr_en = 1'b0;
    logic [ML-1:0] wr_addr = '0;
    logic [AW-1:0] wr_data = '0;
    logic          busy2;
    logic          busy3;
`ifdef L2_STATS_EN
    logic [15:0]   fill2, abort2, fill3, abort3;
`endif

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    l2_instr_responder_if #(.ADDR_W(AW)) bus2 ();
    l2_instr_responder_if #(.ADDR_W(AW)) bus3 ();

    assign bus2.Bus_Gnt_any = gnt2;
    assign bus2.Address_Com = addr;
    assign bus3.Bus_Gnt_any = gnt3;
    assign bus3.Address_Com = addr;

    l2_instr_responder #(
        .ADDR_W(AW), .MEM_WORDS_LOG2(ML), .RESP_LATENCY(2)
    ) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave),
        .Mem_wr_en(wr_en), .Mem_wr_addr(wr_addr),
        .Mem_wr_data(wr_data),
`ifdef L2_STATS_EN
        .Fill_count(fill2), .Abort_count(abort2),
`endif
        .Busy(busy2)
    );

    l2_instr_responder #(
        .ADDR_W(AW), .MEM_WORDS_LOG2(ML), .RESP_LATENCY(3)
    ) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3.slave),
        .Mem_wr_en(wr_en), .Mem_wr_addr(wr_addr),
        .Mem_wr_data(wr_data),
`ifdef L2_STATS_EN
        .Fill_count(fill3), .Abort_count(abort3),
`endif
        .Busy(busy3)
    );

    // Reference model: a request is a start edge plus a due edge;
    // the strobe is high once the due edge has passed.
    int            ncyc = 0;
    bit            m_act [2];
    bit            m_gap [2];
    int            m_due [2];
    logic [AW-3:0] m_word [2];
    int            m_fill [2];
    int            m_abort [2];
    logic [AW-1:0] mmem [1<<ML];

    task automatic model_edge();
        int n;
        int lat;
        logic g;
        bit resp;
        n = ncyc;
        if (wr_en) mmem[wr_addr] = wr_data;
        for (int d = 0; d < 2; d++) begin
            g = (d == 0) ? gnt2 : gnt3;
            lat = (d == 0) ? 2 : 3;
            resp = m_act[d] && (n - 1 >= m_due[d]);
            if (rst) begin
                m_act[d] = 0;
                m_gap[d] = 0;
                m_fill[d] = 0;
                m_abort[d] = 0;
            end else if (m_gap[d]) begin
                m_gap[d] = 0;
            end else if (!m_act[d] ||
                         (g && resp && addr[AW-1:2] != m_word[d])) begin
                if (g) begin
                    m_act[d] = 1;
                    m_word[d] = addr[AW-1:2];
                    m_due[d] = n + lat - 1;
                    m_fill[d]++;
                end
            end else if (!g) begin
                if (resp) m_gap[d] = 1;
                else m_abort[d]++;
                m_act[d] = 0;
            end
        end
        ncyc++;
    endtask

    function automatic bit exp_din(int d);
        return m_act[d] && (ncyc - 1 >= m_due[d]);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_dut(int d);
        logic          din;
        logic          bsy;
        logic [AW-1:0] dat;
        din = (d == 0) ? bus2.Data_in_Bus : bus3.Data_in_Bus;
        bsy = (d == 0) ? busy2 : busy3;
        dat = (d == 0) ? bus2.Data_Bus_Com : bus3.Data_Bus_Com;
        check($sformatf("rnd%0d.din@%0d", d, ncyc), 32'(din),
              32'(exp_din(d)));
        check($sformatf("rnd%0d.busy@%0d", d, ncyc), 32'(bsy),
              32'(m_act[d] || m_gap[d]));
        if (exp_din(d))
            check($sformatf("rnd%0d.data@%0d", d, ncyc), dat,
                  mmem[m_word[d][ML-1:0]]);
`ifdef L2_STATS_EN
        check($sformatf("rnd%0d.fill", d),
              32'((d == 0) ? fill2 : fill3), 32'(m_fill[d]));
        check($sformatf("rnd%0d.abort", d),
              32'((d == 0) ? abort2 : abort3), 32'(m_abort[d]));
`endif
    endtask

    typedef struct {
        logic          gnt;
        logic [AW-1:0] a;
        logic          we;
        logic [ML-1:0] wa;
        logic [AW-1:0] wd;
        logic          din;
        logic          busy;
        logic [AW-1:0] data;
    } vec_t;

    vec_t          tv [13];
    logic [AW-1:0] alist [4];

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{1'b1, 32'h10, 1'b0, 10'd0, 32'h0, 1'b0, 1'b1, 32'h0};
        tv[1]  = '{1'b1, 32'h10, 1'b0, 10'd0, 32'h0, 1'b1, 1'b1,
                   32'hDEAD_BEEF};
        tv[2]  = '{1'b1, 32'h10, 1'b0, 10'd0, 32'h0, 1'b1, 1'b1,
                   32'hDEAD_BEEF};
        tv[3]  = '{1'b1, 32'h10, 1'b1, 10'd4, 32'hCAFE_0001, 1'b1, 1'b1,
                   32'hCAFE_0001};
        tv[4]  = '{1'b1, 32'h20, 1'b0, 10'd0, 32'h0, 1'b0, 1'b1, 32'h0};
        tv[5]  = '{1'b1, 32'h20, 1'b0, 10'd0, 32'h0, 1'b1, 1'b1,
                   32'h1234_5678};
        tv[6]  = '{1'b0, 32'h20, 1'b0, 10'd0, 32'h0, 1'b0, 1'b1, 32'h0};
        tv[7]  = '{1'b1, 32'h13, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 32'h0};
        tv[8]  = '{1'b1, 32'h13, 1'b0, 10'd0, 32'h0, 1'b0, 1'b1, 32'h0};
        tv[9]  = '{1'b1, 32'h13, 1'b0, 10'd0, 32'h0, 1'b1, 1'b1,
                   32'hCAFE_0001};
        tv[10] = '{1'b1, 32'h10, 1'b0, 10'd0, 32'h0, 1'b1, 1'b1,
                   32'hCAFE_0001};
        tv[11] = '{1'b0, 32'h10, 1'b0, 10'd0, 32'h0, 1'b0, 1'b1, 32'h0};
        tv[12] = '{1'b0, 32'h10, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 32'h0};
        alist = '{32'h10, 32'h13, 32'h20, 32'hABC0_0010};

        // Reset state
        tick();
        tick();
        check("reset.busy2", 32'(busy2), 0);
        check("reset.din2", 32'(bus2.Data_in_Bus), 0);
        check("reset.busy3", 32'(busy3), 0);
        check("reset.din3", 32'(bus3.Data_in_Bus), 0);
`ifdef L2_STATS_EN
        check("reset.fill2", 32'(fill2), 0);
        check("reset.abort3", 32'(abort3), 0);
`endif
        rst = 1'b0;

        // Preload the first 64 words
        for (int i = 0; i < 64; i++) begin
            wr_en = 1'b1;
            wr_addr = ML'(i);
            wr_data = (i == 4) ? 32'hDEAD_BEEF :
                      (i == 8) ? 32'h1234_5678 : $urandom;
            tick();
        end
        wr_en = 1'b0;

        // Directed table on the latency-2 instance
        for (int i = 0; i < 13; i++) begin
            gnt2 = tv[i].gnt;
            addr = tv[i].a;
            wr_en = tv[i].we;
            wr_addr = tv[i].wa;
            wr_data = tv[i].wd;
            tick();
            check($sformatf("tv%0d.din", i), 32'(bus2.Data_in_Bus),
                  32'(tv[i].din));
            check($sformatf("tv%0d.busy", i), 32'(busy2),
                  32'(tv[i].busy));
            if (tv[i].din)
                check($sformatf("tv%0d.data", i), bus2.Data_Bus_Com,
                      tv[i].data);
        end
        wr_en = 1'b0;
`ifdef L2_STATS_EN
        check("table.fill2", 32'(fill2), 3);
`endif

        // Abort in WAIT on the latency-3 instance
        addr = 32'h10;
        gnt3 = 1'b1;
        tick();
        check("abort.busy_cap", 32'(busy3), 1);
        check("abort.din_cap", 32'(bus3.Data_in_Bus), 0);
        gnt3 = 1'b0;
        tick();
        check("abort.busy", 32'(busy3), 0);
        check("abort.din", 32'(bus3.Data_in_Bus), 0);
        tick();
        check("abort.din_after", 32'(bus3.Data_in_Bus), 0);
`ifdef L2_STATS_EN
        check("abort.count", 32'(abort3), 1);
`endif

        // Reset in the middle of a response
        addr = 32'h20;
        gnt2 = 1'b1;
        tick();
        tick();
        check("rstmid.din_pre", 32'(bus2.Data_in_Bus), 1);
        check("rstmid.data_pre", bus2.Data_Bus_Com, 32'h1234_5678);
        #2 rst = 1'b1;
        #1;
        check("rstmid.din_async", 32'(bus2.Data_in_Bus), 0);
        check("rstmid.busy_async", 32'(busy2), 0);
        tick();
        check("rstmid.busy_held", 32'(busy2), 0);
        rst = 1'b0;
        tick();
        check("rstmid.recap_busy", 32'(busy2), 1);
        check("rstmid.recap_din", 32'(bus2.Data_in_Bus), 0);
        tick();
        check("rstmid.resp_din", 32'(bus2.Data_in_Bus), 1);
        check("rstmid.resp_data", bus2.Data_Bus_Com, 32'h1234_5678);
        gnt2 = 1'b0;
        tick();
        check("rstmid.release", 32'(busy2), 1);
        tick();
        check("rstmid.idle", 32'(busy2), 0);

        // Random traffic on both instances against the model
        for (int i = 0; i < 600; i++) begin
            gnt2 = gnt2 ? ($urandom_range(0, 7) != 0)
                        : ($urandom_range(0, 2) == 0);
            gnt3 = gnt3 ? ($urandom_range(0, 7) != 0)
                        : ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    addr = alist[$urandom_range(0, 3)];
                end else begin
                    addr = $urandom;
                    addr[11:8] = 4'h0;
                end
            end
            wr_en = ($urandom_range(0, 7) == 0);
            wr_addr = ($urandom_range(0, 1) == 0) ? addr[11:2]
                                                  : ML'($urandom_range(0, 63));
            wr_data = $urandom;
            tick();
            check_dut(0);
            check_dut(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/l2_instr_responder.md
Name: l2_instr_responder

Overview:
- Stub L2 instruction memory that answers line fills requested by the instruction caches over the common instruction bus.
- It is the responder for the miss path of each instruction cache. When an arbiter grant is active, it captures Address_Com, waits a fixed latency, then drives the word onto Data_Bus_Com with Data_in_Bus high. It holds that response until the grant drops.
- It includes a bench/boot backdoor write port for loading memory contents.

Parameters:
- ADDR_W, 32, width of Address_Com and Data_Bus_Com.
- MEM_WORDS_LOG2, 10, log2 of the stub memory depth in words. The index is Address_Com[MEM_WORDS_LOG2+1:2].
- RESP_LATENCY, 2, cycles from the capture edge to the first edge with Data_in_Bus high. Legal range 1..15.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- Bus_Gnt_any, input, 1, OR of all Com_Bus_Gnt_proc grants from the arbiter.
- Address_Com, inout, ADDR_W, common address bus. This block only reads it.
- Data_Bus_Com, inout, ADDR_W, common data bus. Driven only in RESPOND, otherwise Z.
- Data_in_Bus, inout, 1, data-valid strobe. Driven 1 in RESPOND, otherwise Z. The bench provides a weak pull-down.
- Mem_wr_en, input, 1, backdoor write enable.
- Mem_wr_addr, input, MEM_WORDS_LOG2, backdoor word index.
- Mem_wr_data, input, ADDR_W, backdoor write data.
- Busy, output, 1, high in any state except IDLE.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset values: state IDLE, latency counter 0, captured address 0, Busy 0, Data_Bus_Com Z, Data_in_Bus Z. Memory contents are not cleared.
- The FSM has four states: IDLE, WAIT, RESPOND, RELEASE.
- IDLE:
  - Bus_Gnt_any=1 at a posedge: capture Address_Com, with bits [1:0] forced to 0, as addr_q.
  - Load the counter with RESP_LATENCY-1.
  - If RESP_LATENCY=1, go to RESPOND; otherwise go to WAIT.
- WAIT:
  - Decrement the counter each cycle. Go to RESPOND on the edge where the counter reaches 0.
  - Bus_Gnt_any=0 in WAIT aborts: go to IDLE and do not drive the bus.
- RESPOND:
  - Combinationally drive Data_Bus_Com = mem[addr_q index] and Data_in_Bus = 1.
  - The driven data is read from the array each cycle, so a backdoor write to addr_q takes effect on the next cycle.
- RESPOND exits (priority order):
  - Bus_Gnt_any=0: go to RELEASE.
  - Else Address_Com[ADDR_W-1:2] differs from addr_q. This is a new requester under a continuous grant. Capture the new address, reload the counter, go to WAIT (or stay in RESPOND if RESP_LATENCY=1). Data_in_Bus must drop for at least that one cycle only when RESP_LATENCY>1.
  - Otherwise stay in RESPOND.
- RELEASE: one cycle with the bus at Z, then go to IDLE. A grant seen in RELEASE is ignored. This guarantees a one-cycle turnaround gap before the next request is captured.
- Latency: the first cycle with Data_in_Bus=1 starts RESP_LATENCY clocks after the capture edge.
- Backdoor write: synchronous on posedge. It has priority over nothing, because reads are combinational. A write to the same index as a response in progress updates Data_Bus_Com on the following cycle.
- Addresses above the memory depth alias by truncation. No error is flagged.
- rst asserted in any state: the bus goes to Z immediately (asynchronously), FSM goes to IDLE. No partial response follows deassertion.

Optional Feature:
- Macro: L2_STATS_EN.
- When defined:
  - Adds output Fill_count, 16 bits, reset 0. It increments on every IDLE/RESPOND to WAIT/RESPOND capture and saturates at 16'hFFFF.
  - Adds output Abort_count, 16 bits, reset 0. It increments on each WAIT to IDLE abort and saturates.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared package/defines:
  - FSM state encoding L2R_IDLE=2'b00, L2R_WAIT=2'b01, L2R_RESPOND=2'b10, L2R_RELEASE=2'b11.
  - Address field positions (BLK_OFFSET, INDEX, TAG), reused from the cache definitions.
- One natural sub-module: l2_stub_mem, a single-port array with a synchronous write and an asynchronous read. Everything else stays in the top.

Test Plan:
- Basic fill: preload mem[0x004]=32'hDEAD_BEEF. Raise Bus_Gnt_any with Address_Com=32'h0000_0010. Expected: Data_in_Bus=1 and Data_Bus_Com=DEADBEEF starting 2 clocks after the capture edge. Drop the grant: one RELEASE cycle of Z, then IDLE with Busy=0.
- Offset masking: request Address_Com=32'h0000_0013. Expected: response is mem[0x004], the same as for 0x10.
- Abort: drop Bus_Gnt_any one cycle after capture with RESP_LATENCY=3. Expected: Data_in_Bus never 1, return to IDLE. With L2_STATS_EN, Abort_count=1.
- Back-to-back requesters: grant held and Address_Com changes from 0x10 to 0x20 while in RESPOND, with mem[8]=32'h1234_5678. Expected: Data_in_Bus low for 1 cycle, then 12345678 after 2 clocks.
- Reset mid-response: assert rst while in RESPOND. Expected: Data_Bus_Com and Data_in_Bus go to Z the same cycle and Busy=0. After deassertion with the grant high, a fresh capture and full latency follow.
- Backdoor during response: write mem[4]=32'hCAFE_0001 while responding to 0x10. Expected: Data_Bus_Com changes to CAFE0001 on the next cycle, with Data_in_Bus staying 1.
